// File: rtl/user_pwd_check.sv
// Password-check stage of the door controller: collects four digits for an
// already-accepted user ID, compares against the enrolled credentials and
// grants access or locks the user out after MAX_TRIES failed attempts.
module user_pwd_check #(
  parameter int          MAX_TRIES = 3,
  parameter logic [15:0] USER0_ID  = 16'hABC1,
  parameter logic [15:0] USER0_PWD = 16'h1234,
  parameter logic [15:0] USER1_ID  = 16'h5678,
  parameter logic [15:0] USER1_PWD = 16'h9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        user_allow,
  input  logic [15:0] id_in,
  input  logic        load_input,
  input  logic [3:0]  pwd_input,
  output logic        pwd_allow,
  output logic        lock_out,
  output logic [1:0]  attempt_count,
  output logic [3:0]  pwd_seg,
  output logic [2:0]  digit_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    CHECK   = 3'd2,
    GRANTED = 3'd3,
    LOCKED  = 3'd4
  } state_t;

  localparam logic [1:0] MAX_CNT = 2'(MAX_TRIES);

  state_t      state_q, state_d;
  logic [15:0] id_q, id_d;
  logic [15:0] pwd_q, pwd_d;
  logic [3:0]  seg_q, seg_d;
  logic [2:0]  digit_q, digit_d;
  logic [1:0]  attempt_q, attempt_d;
  logic        allow_q, allow_d;
  logic        lock_q, lock_d;

  logic        pwd_match;
  logic [1:0]  attempt_inc;
  logic        last_try;

  // Credential comparison; an ID that is not enrolled can never match
  always_comb begin
    pwd_match   = ((id_q == USER0_ID) && (pwd_q == USER0_PWD)) ||
                  ((id_q == USER1_ID) && (pwd_q == USER1_PWD));
    attempt_inc = attempt_q + 2'd1;
    last_try    = (attempt_inc == MAX_CNT);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      id_q      <= '0;
      pwd_q     <= '0;
      seg_q     <= '0;
      digit_q   <= '0;
      attempt_q <= '0;
      allow_q   <= 1'b0;
      lock_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      pwd_q     <= pwd_d;
      seg_q     <= seg_d;
      digit_q   <= digit_d;
      attempt_q <= attempt_d;
      allow_q   <= allow_d;
      lock_q    <= lock_d;
    end
  end

  // Next-state selection; dropping user_allow aborts any open session
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (user_allow) state_d = ENTRY;
      end
      ENTRY: begin
        if (!user_allow)                          state_d = IDLE;
        else if (load_input && digit_q == 3'd3)   state_d = CHECK;
      end
      CHECK: begin
        if (!user_allow)    state_d = IDLE;
        else if (pwd_match) state_d = GRANTED;
        else if (last_try)  state_d = LOCKED;
        else                state_d = ENTRY;
      end
      GRANTED: begin
        if (!user_allow) state_d = IDLE;
      end
      LOCKED: begin
        state_d = LOCKED;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs and the digit shift register
  always_comb begin
    id_d      = id_q;
    pwd_d     = pwd_q;
    seg_d     = seg_q;
    digit_d   = digit_q;
    attempt_d = attempt_q;
    allow_d   = allow_q;
    lock_d    = lock_q;
    case (state_q)
      IDLE: begin
        if (user_allow) begin
          id_d      = id_in;
          pwd_d     = '0;
          digit_d   = '0;
          attempt_d = '0;
        end
      end
      ENTRY, CHECK, GRANTED: begin
        if (!user_allow) begin
          pwd_d     = '0;
          seg_d     = '0;
          digit_d   = '0;
          attempt_d = '0;
          allow_d   = 1'b0;
        end else if (state_q == ENTRY) begin
          if (load_input) begin
            pwd_d   = {pwd_q[11:0], pwd_input};
            seg_d   = pwd_input;
            digit_d = digit_q + 3'd1;
          end
        end else if (state_q == CHECK) begin
          if (pwd_match) begin
            allow_d = 1'b1;
          end else begin
            attempt_d = attempt_inc;
            pwd_d     = '0;
            digit_d   = '0;
            if (last_try) lock_d = 1'b1;
          end
        end
      end
      default: begin
      end
    endcase
  end

  assign pwd_allow     = allow_q;
  assign lock_out      = lock_q;
  assign attempt_count = attempt_q;
  assign pwd_seg       = seg_q;
  assign digit_count   = digit_q;

endmodule
